// File: rtl/char_power.sv
// char_power: character power-state controller (small/grow/big/shrink/dead)
module char_power #(
    parameter int         GROW_FRAMES  = 48,
    parameter int         INV_FRAMES   = 120,
    parameter int         DEATH_FRAMES = 90,
    parameter int         BLINK_SHIFT  = 2,
    parameter logic [9:0] H_SMALL      = 10'd12,
    parameter logic [9:0] H_BIG        = 10'd24
) (
    input  logic       sys_clk,
    input  logic       RST_N,
    input  logic       frame_tick,
    input  logic       restart,
    input  logic       touch_g_ms,
    input  logic       touch_enemy,
    output logic       is_big,
    output logic [9:0] char_h,
    output logic       visible,
    output logic       invincible,
    output logic       freeze,
    output logic       dead,
    output logic       pwr_up,
    output logic       game_over
);
    // OVER is DEAD after the death animation has finished; it keeps fcnt and suppresses a second game_over
    typedef enum logic [2:0] {SMALL, GROW, BIG, SHRINK, DEAD, OVER} state_t;
    state_t     state, nstate;
    logic [7:0] fcnt, nfcnt, lim;
    logic       ms_prev, mu_rise, timed, expire, npwr, ngo;
    always_comb begin
        mu_rise = touch_g_ms & ~ms_prev;
        timed   = state == GROW || state == SHRINK || state == DEAD;
        lim     = state == GROW ? 8'(GROW_FRAMES - 1) : state == SHRINK ? 8'(INV_FRAMES - 1) : 8'(DEATH_FRAMES - 1);
        expire  = timed && frame_tick && fcnt == lim;
        nstate  = state;
        case (state)
            SMALL:   nstate = mu_rise ? GROW : touch_enemy ? DEAD : SMALL;
            GROW:    nstate = expire ? BIG : GROW;
            BIG:     nstate = touch_enemy ? SHRINK : BIG;
            SHRINK:  nstate = expire ? SMALL : SHRINK;
            DEAD:    nstate = expire ? OVER : DEAD;
            default: nstate = OVER;
        endcase
        if (restart) nstate = SMALL;
        npwr  = ~restart & mu_rise & (state == SMALL || state == BIG);
        ngo   = ~restart & expire & state == DEAD;
        nfcnt = restart ? 8'd0 : ngo ? fcnt : nstate != state ? 8'd0 : timed && frame_tick ? fcnt + 8'd1 : fcnt;
    end
    always_ff @(posedge sys_clk or negedge RST_N) begin
        if (!RST_N) begin
            state      <= SMALL;
            fcnt       <= 8'd0;
            ms_prev    <= 1'b0;
            is_big     <= 1'b0;
            char_h     <= H_SMALL;
            visible    <= 1'b1;
            invincible <= 1'b0;
            freeze     <= 1'b0;
            dead       <= 1'b0;
            pwr_up     <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            state      <= nstate;
            fcnt       <= nfcnt;
            ms_prev    <= touch_g_ms;
            is_big     <= nstate == BIG;
            char_h     <= nstate == BIG ? H_BIG : H_SMALL;
            visible    <= nstate == GROW || nstate == SHRINK ? ~nfcnt[BLINK_SHIFT] : 1'b1;
            invincible <= nstate == GROW || nstate == SHRINK;
            freeze     <= nstate == GROW || nstate == DEAD || nstate == OVER;
            dead       <= nstate == DEAD || nstate == OVER;
            pwr_up     <= npwr;
            game_over  <= ngo;
        end
    end
endmodule

// File: tb/tb_char_power.sv
// tb_char_power: randomized and directed checks of char_power against a tick-counting reference model
module tb_char_power;
    localparam int         GF = 48, IF = 120, DF = 90, BS = 2;
    localparam logic [9:0] HS = 10'd12, HB = 10'd24;
    localparam int         SM = 0, GR = 1, BG = 2, SH = 3, DD = 4;
    localparam logic [16:0] RST_VEC = {1'b0, HS, 1'b1, 5'b00000};
    logic       sys_clk = 0, RST_N = 0, frame_tick = 0, restart = 0, touch_g_ms = 0, touch_enemy = 0;
    logic       is_big, visible, invincible, freeze, dead, pwr_up, game_over;
    logic [9:0] char_h;
    logic [16:0] obs;
    int checks = 0, errors = 0;
    int m_mode, m_el;
    bit m_over, m_prev, m_pw, m_go;
    char_power #(.GROW_FRAMES(GF), .INV_FRAMES(IF), .DEATH_FRAMES(DF), .BLINK_SHIFT(BS), .H_SMALL(HS), .H_BIG(HB)) dut (
        .sys_clk(sys_clk), .RST_N(RST_N), .frame_tick(frame_tick), .restart(restart),
        .touch_g_ms(touch_g_ms), .touch_enemy(touch_enemy), .is_big(is_big), .char_h(char_h),
        .visible(visible), .invincible(invincible), .freeze(freeze), .dead(dead),
        .pwr_up(pwr_up), .game_over(game_over));
    assign obs = {is_big, char_h, visible, invincible, freeze, dead, pwr_up, game_over};
    always #5 sys_clk = ~sys_clk;
    task automatic model_reset();
        m_mode = SM; m_el = 0; m_over = 0; m_prev = 0; m_pw = 0; m_go = 0;
    endtask
    // m_el counts frame ticks since entering the current mode
    function automatic logic [16:0] expv();
        logic b, v, inv, frz, dd;
        b   = m_mode == BG;
        inv = m_mode == GR || m_mode == SH;
        v   = inv ? ((m_el >> BS) % 2 == 0) : 1'b1;
        frz = m_mode == GR || m_mode == DD;
        dd  = m_mode == DD;
        return {b, b ? HB : HS, v, inv, frz, dd, m_pw, m_go};
    endfunction
    task automatic step(input logic ft, input logic rs, input logic ms, input logic en);
        bit rise;
        frame_tick = ft; restart = rs; touch_g_ms = ms; touch_enemy = en;
        @(posedge sys_clk);
        rise = ms && !m_prev;
        m_prev = ms; m_pw = 0; m_go = 0;
        if (rs) begin
            m_mode = SM; m_el = 0; m_over = 0;
        end else case (m_mode)
            SM: if (rise) begin m_mode = GR; m_el = 0; m_pw = 1; end
                else if (en) begin m_mode = DD; m_el = 0; end
            GR: if (ft) begin m_el++; if (m_el == GF) begin m_mode = BG; m_el = 0; end end
            BG: begin m_pw = rise; if (en) begin m_mode = SH; m_el = 0; end end
            SH: if (ft) begin m_el++; if (m_el == IF) begin m_mode = SM; m_el = 0; end end
            default: if (ft && !m_over) begin m_el++; if (m_el == DF) begin m_over = 1; m_go = 1; end end
        endcase
        #1;
    endtask
    task automatic test_reset();
        @(posedge sys_clk); #1;
        checks++;
        if (obs !== RST_VEC) begin errors++; $display("FAIL reset_values got %h want %h", obs, RST_VEC); end
        @(negedge sys_clk); RST_N = 1;
        model_reset();
    endtask
    task automatic test_grow();
        int pw = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0);
            pw += pwr_up;
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL grow_entry cyc %0d got %h want %h", i, obs, expv()); end
        end
        checks++;
        if (pw !== 1) begin errors++; $display("FAIL grow_single_pwr_up got %0d want 1", pw); end
        for (int i = 0; i < 2 * GF; i++) begin
            step(i % 2, 0, 0, 1'(i % 3 == 0));
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL grow_blink cyc %0d got %h want %h", i, obs, expv()); end
        end
        checks++;
        if ({is_big, char_h, freeze} !== {1'b1, HB, 1'b0}) begin
            errors++; $display("FAIL grow_to_big got %b/%0d/%b want 1/%0d/0", is_big, char_h, freeze, HB);
        end
    endtask
    task automatic test_shrink();
        step(0, 0, 0, 1);
        checks++;
        if ({is_big, char_h, invincible} !== {1'b0, HS, 1'b1}) begin
            errors++; $display("FAIL shrink_hit got %b/%0d/%b want 0/%0d/1", is_big, char_h, invincible, HS);
        end
        for (int i = 0; i < IF; i++) begin
            step(1, 0, 0, 1);
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL shrink_run tick %0d got %h want %h", i, obs, expv()); end
        end
        checks++;
        if ({dead, invincible} !== 2'b00) begin errors++; $display("FAIL shrink_exit_small got %b%b want 00", dead, invincible); end
        step(0, 0, 0, 1);
        checks++;
        if (dead !== 1'b1) begin errors++; $display("FAIL shrink_then_dead got %b want 1", dead); end
    endtask
    task automatic test_simul();
        step(0, 1, 0, 0);
        step(0, 0, 1, 1);
        checks++;
        if ({pwr_up, dead, freeze} !== 3'b101) begin
            errors++; $display("FAIL simul_mushroom_wins got %b%b%b want 101", pwr_up, dead, freeze);
        end
        step(0, 0, 0, 0);
    endtask
    task automatic test_death();
        int go = 0;
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        checks++;
        if ({dead, freeze} !== 2'b11) begin errors++; $display("FAIL death_entry got %b%b want 11", dead, freeze); end
        for (int i = 0; i < DF + 20; i++) begin
            step(1, 0, 0, 0);
            go += game_over;
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL death_run tick %0d got %h want %h", i, obs, expv()); end
        end
        checks++;
        if (go !== 1) begin errors++; $display("FAIL death_game_over_count got %0d want 1", go); end
        step(0, 1, 0, 0);
        checks++;
        if (obs !== RST_VEC) begin errors++; $display("FAIL death_restart got %h want %h", obs, RST_VEC); end
    endtask
    task automatic test_async();
        step(0, 0, 1, 0);
        for (int i = 0; i < GF; i++) step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        for (int i = 0; i < 60; i++) step(1, 0, 0, 0);
        checks++;
        if (obs !== expv() || invincible !== 1'b1) begin errors++; $display("FAIL async_setup got %h want %h", obs, expv()); end
        #1 RST_N = 0;
        #1;
        checks++;
        if (obs !== RST_VEC) begin errors++; $display("FAIL async_reset got %h want %h", obs, RST_VEC); end
        model_reset();
        @(negedge sys_clk); RST_N = 1;
        step(1, 0, 0, 0);
        checks++;
        if (obs !== RST_VEC) begin errors++; $display("FAIL async_release_small got %h want %h", obs, RST_VEC); end
    endtask
    task automatic test_random();
        logic ms = 0, en = 0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 9) == 0) ms = ~ms;
            if ($urandom_range(0, 14) == 0) en = ~en;
            step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 299) == 0), ms, en);
            checks++;
            if (obs !== expv()) begin errors++; $display("FAIL random cyc %0d got %h want %h", i, obs, expv()); end
        end
    endtask
    initial begin
        model_reset();
        test_reset();
        test_grow();
        test_shrink();
        test_simul();
        test_death();
        test_async();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
